bit_deserializer: RTL and testbench

Serial-to-parallel stage that consumes the 1-bit registered stream produced by the upstream D flip-flop stage and assembles it into WIDTH-bit words. Words go to the downstream consumer over a valid/ready handshake through a one-entry output holding register. Frame alignment comes from a start-of-frame marker. Overflow is reported when a word completes while the holding register is still occupied.

---
 rtl/bit_deser_pkg.sv | 22 ++
 rtl/bit_deserializer_if.sv | 21 ++
 rtl/bit_deser_shift.sv | 80 ++++++++
 rtl/bit_deserializer.sv | 91 +++++++++
 tb/tb_bit_deserializer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bit_deser_pkg.sv
// Shared types and sizing helpers for the bit deserializer.
// Optional feature macro: BIT_DESER_PARITY_EN (adds a trailing even-parity bit).
package bit_deser_pkg;

  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;

  localparam int DESER_WIDTH_DEFAULT = 8;
  localparam int DESER_WIDTH_MAX     = 32;

  function automatic int frame_len(input int w);
`ifdef BIT_DESER_PARITY_EN
    return w + 1;
`else
    return w;
`endif
  endfunction

  function automatic int cnt_w(input int w);
    return $clog2(frame_len(w) + 1);
  endfunction

endpackage

// File: rtl/bit_deserializer_if.sv
// Word-side valid/ready handshake of the deserializer.
// master: word_out/word_valid out, word_ready in; slave is the consumer.
interface bit_deserializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;

  modport master (
    output word_out,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_out,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/bit_deser_shift.sv
// Shift register, bit counter, sof realignment and completion pulse.
// Ports: bit stream in; next word, done pulse, bit_cnt (+parity_err) out.
module bit_deser_shift
  import bit_deser_pkg::*;
#(
  parameter int   WIDTH     = DESER_WIDTH_DEFAULT,
  parameter bit   MSB_FIRST = 1'b1,
  localparam int  CW        = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] word_nxt,
  output logic             done,
`ifdef BIT_DESER_PARITY_EN
  output logic             parity_err,
`endif
  output logic [CW-1:0]    cnt
);

  localparam int            FLEN = frame_len(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(FLEN - 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] base;
  logic [CW-1:0]    eff_cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             sof_q;
  logic             last;
  logic             shift_en;
`ifdef BIT_DESER_PARITY_EN
  logic             par_ok;
`endif

  always_comb begin
    sof_q    = sof && bit_valid;
    // sof drops the partial frame: this bit restarts at position 0
    base     = sof_q ? '0 : sr;
    eff_cnt  = sof_q ? '0 : cnt;
    last     = bit_valid && (eff_cnt == LAST);
`ifdef BIT_DESER_PARITY_EN
    // the trailing parity bit is checked, never shifted in
    shift_en = bit_valid && !last;
    par_ok   = ~(^sr ^ bit_in);
    done     = last && par_ok;
`else
    shift_en = bit_valid;
    done     = last;
`endif
    word_nxt = base;
    if (shift_en) begin
      word_nxt = MSB_FIRST ? {base[WIDTH-2:0], bit_in}
                           : {bit_in, base[WIDTH-1:1]};
    end
    cnt_nxt = cnt;
    if (bit_valid) begin
      cnt_nxt = last ? '0 : eff_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else begin
      sr  <= word_nxt;
      cnt <= cnt_nxt;
    end
  end

`ifdef BIT_DESER_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_err <= 1'b0;
    else       parity_err <= last && !par_ok;
  end
`endif

endmodule

// File: rtl/bit_deserializer.sv
// Serial-to-parallel deserializer with one-entry output holding register.
// Ports: clk/reset, bit_in/bit_valid/sof, out_if (word handshake),
// overflow/ovf_clr, bit_cnt; parity_err when BIT_DESER_PARITY_EN is defined.
module bit_deserializer
  import bit_deser_pkg::*;
#(
  parameter int  WIDTH     = DESER_WIDTH_DEFAULT,
  parameter bit  MSB_FIRST = 1'b1,
  localparam int CW        = cnt_w(WIDTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bit_in,
  input  logic                bit_valid,
  input  logic                sof,
  bit_deserializer_if.master  out_if,
  output logic                overflow,
  input  logic                ovf_clr,
`ifdef BIT_DESER_PARITY_EN
  output logic                parity_err,
`endif
  output logic [CW-1:0]       bit_cnt
);

  out_state_e       state;
  out_state_e       state_nxt;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] word_nxt;
  logic             done;
  logic             load;
  logic             drop;

  bit_deser_shift #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk        (clk),
    .reset      (reset),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .sof        (sof),
    .word_nxt   (word_nxt),
    .done       (done),
`ifdef BIT_DESER_PARITY_EN
    .parity_err (parity_err),
`endif
    .cnt        (bit_cnt)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    unique case (state)
      OUT_EMPTY: begin
        if (done) begin
          state_nxt = OUT_FULL;
          load      = 1'b1;
        end
      end
      OUT_FULL: begin
        // a word arriving as the old one leaves replaces it, no bubble
        if (done && out_if.word_ready) begin
          load = 1'b1;
        end else if (done) begin
          drop = 1'b1;
        end else if (out_if.word_ready) begin
          state_nxt = OUT_EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= OUT_EMPTY;
      hold     <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) hold <= word_nxt;
      // set beats clear on the same edge
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign out_if.word_out   = hold;
  assign out_if.word_valid = (state == OUT_FULL);

endmodule

// File: tb/tb_bit_deserializer.sv
// Self-checking bench: MSB-first and LSB-first instances share one stream.
// Table-driven frames through a scoreboard plus hand-written corner cases.
module tb_bit_deserializer;

`ifdef BIT_DESER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       tb_clk = 1'b0;
  logic       reset;
  logic       bit_in;
  logic       bit_valid;
  logic       sof;
  logic       word_ready;
  logic       ovf_clr;
  logic       ovf_m;
  logic       ovf_l;
  logic [3:0] cnt_m;
  logic [3:0] cnt_l;
`ifdef BIT_DESER_PARITY_EN
  logic       perr_m;
  logic       perr_l;
`endif

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  logic [7:0] q_m[$];
  logic [7:0] q_l[$];

  always #5 tb_clk = ~tb_clk;

  bit_deserializer_if #(.WIDTH(8)) if_m ();
  bit_deserializer_if #(.WIDTH(8)) if_l ();
  assign if_m.word_ready = word_ready;
  assign if_l.word_ready = word_ready;

  bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk        (tb_clk),
    .reset      (reset),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .sof        (sof),
    .out_if     (if_m),
    .overflow   (ovf_m),
    .ovf_clr    (ovf_clr),
`ifdef BIT_DESER_PARITY_EN
    .parity_err (perr_m),
`endif
    .bit_cnt    (cnt_m)
  );

  bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk        (tb_clk),
    .reset      (reset),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .sof        (sof),
    .out_if     (if_l),
    .overflow   (ovf_l),
    .ovf_clr    (ovf_clr),
`ifdef BIT_DESER_PARITY_EN
    .parity_err (perr_l),
`endif
    .bit_cnt    (cnt_l)
  );

  typedef struct {
    logic [7:0] w;
    logic [7:0] exp_m;
    logic [7:0] exp_l;
    int         gap;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] w, input int hi,
                           input int lo, input bit use_sof);
    for (int i = hi; i >= lo; i--) begin
      bit_in    = w[i];
      bit_valid = 1'b1;
      sof       = use_sof && (i == hi);
      tick();
    end
    bit_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic send_par(input logic [7:0] w, input bit bad_par);
    bit_in    = (^w) ^ bad_par;
    bit_valid = 1'b1;
    sof       = 1'b0;
    tick();
    bit_valid = 1'b0;
  endtask

  // rdy/clr flags apply only on the frame's completing edge
  task automatic send_frame(input logic [7:0] w, input bit use_sof,
                            input bit bad_par, input bit rdy_last,
                            input bit clr_last);
    send_bits(w, 7, 1, use_sof);
    if (rdy_last) word_ready = 1'b1;
    if (clr_last) ovf_clr = 1'b1;
    if (PAR) begin
      send_bits(w, 0, 0, 1'b0);
      send_par(w, bad_par);
    end else begin
      send_bits(w, 0, 0, 1'b0);
    end
    ovf_clr = 1'b0;
    if (rdy_last) word_ready = 1'b0;
  endtask

  // transfer happens on the next rising edge when valid && ready here
  always @(negedge tb_clk) begin
    logic [7:0] e;
    if (mon_en && if_m.word_valid && word_ready) begin
      if (q_m.size() == 0) chk("sb_m_empty", 32'd1, 32'd0);
      else begin
        e = q_m.pop_front();
        chk("sb_m", {24'd0, if_m.word_out}, {24'd0, e});
      end
    end
    if (mon_en && if_l.word_valid && word_ready) begin
      if (q_l.size() == 0) chk("sb_l_empty", 32'd1, 32'd0);
      else begin
        e = q_l.pop_front();
        chk("sb_l", {24'd0, if_l.word_out}, {24'd0, e});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{8'hA5, 8'hA5, 8'hA5, 0};
    tbl[1] = '{8'hC0, 8'hC0, 8'h03, 0};
    tbl[2] = '{8'h3C, 8'h3C, 8'h3C, 1};
    tbl[3] = '{8'h01, 8'h01, 8'h80, 0};
    tbl[4] = '{8'hF0, 8'hF0, 8'h0F, 2};
    tbl[5] = '{8'h12, 8'h12, 8'h48, 0};
    tbl[6] = '{8'hFF, 8'hFF, 8'hFF, 0};
    tbl[7] = '{8'h00, 8'h00, 8'h00, 0};

    reset      = 1'b1;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    sof        = 1'b0;
    word_ready = 1'b0;
    ovf_clr    = 1'b0;
    repeat (2) tick();
    chk("rst_valid", {31'd0, if_m.word_valid}, 32'd0);
    chk("rst_word", {24'd0, if_m.word_out}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_m}, 32'd0);
    chk("rst_cnt", {28'd0, cnt_m}, 32'd0);
    chk("rst_valid_l", {31'd0, if_l.word_valid}, 32'd0);
    reset = 1'b0;
    tick();

    // A5 with ready high: valid for exactly one cycle
    word_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("a5_valid", {31'd0, if_m.word_valid}, 32'd1);
    chk("a5_word_m", {24'd0, if_m.word_out}, 32'hA5);
    chk("a5_word_l", {24'd0, if_l.word_out}, 32'hA5);
    chk("a5_cnt", {28'd0, cnt_m}, 32'd0);
    tick();
    chk("a5_one_cycle", {31'd0, if_m.word_valid}, 32'd0);
    send_frame(8'hC0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("c0_word_m", {24'd0, if_m.word_out}, 32'hC0);
    chk("c0_word_l", {24'd0, if_l.word_out}, 32'h03);
    tick();

    // back-to-back table frames through the scoreboard
    mon_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      q_m.push_back(tbl[k].exp_m);
      q_l.push_back(tbl[k].exp_l);
      send_frame(tbl[k].w, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (tbl[k].gap) tick();
    end
    repeat (2) tick();
    mon_en = 1'b0;
    chk("tbl_q_m", q_m.size(), 32'd0);
    chk("tbl_q_l", q_l.size(), 32'd0);
    chk("tbl_ovf", {31'd0, ovf_m}, 32'd0);
    chk("tbl_idle", {31'd0, if_m.word_valid}, 32'd0);

    // overflow with consumer stalled
    word_ready = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovf_word_m", {24'd0, if_m.word_out}, 32'h3C);
    chk("ovf_word_l", {24'd0, if_l.word_out}, 32'h3C);
    chk("ovf_valid", {31'd0, if_m.word_valid}, 32'd1);
    chk("ovf_set", {31'd0, ovf_m}, 32'd1);
    chk("ovf_set_l", {31'd0, ovf_l}, 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", {31'd0, ovf_m}, 32'd0);
    chk("ovf_hold", {31'd0, if_m.word_valid}, 32'd1);
    send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("ovf_set_wins", {31'd0, ovf_m}, 32'd1);
    chk("ovf_word_kept", {24'd0, if_m.word_out}, 32'h3C);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    chk("ovf_drain", {31'd0, if_m.word_valid}, 32'd0);
    chk("ovf_cleared", {31'd0, ovf_m}, 32'd0);

    // replace: completion and word_ready on the same edge
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rep_first", {24'd0, if_m.word_out}, 32'h11);
    chk("rep_first_l", {24'd0, if_l.word_out}, 32'h88);
    send_frame(8'h22, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("rep_word_m", {24'd0, if_m.word_out}, 32'h22);
    chk("rep_word_l", {24'd0, if_l.word_out}, 32'h44);
    chk("rep_valid", {31'd0, if_m.word_valid}, 32'd1);
    chk("rep_ovf", {31'd0, ovf_m}, 32'd0);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    chk("rep_drain", {31'd0, if_m.word_valid}, 32'd0);

    // sof realignment discards a 3-bit partial frame
    mon_en = 1'b1;
    word_ready = 1'b1;
    q_m.push_back(8'hFF);
    q_l.push_back(8'hFF);
    send_bits(8'hA0, 7, 5, 1'b1);
    chk("sof_partial", {28'd0, cnt_m}, 32'd3);
    send_bits(8'hFF, 7, 7, 1'b1);
    chk("sof_cnt1", {28'd0, cnt_m}, 32'd1);
    send_bits(8'hFF, 6, 0, 1'b0);
    if (PAR) send_par(8'hFF, 1'b0);
    repeat (2) tick();
    chk("sof_q_m", q_m.size(), 32'd0);
    chk("sof_q_l", q_l.size(), 32'd0);

    // reset mid-frame, then a frame without sof must still align
    send_bits(8'hC7, 7, 3, 1'b1);
    chk("rstmid_cnt5", {28'd0, cnt_m}, 32'd5);
    #2 reset = 1'b1;
    #1 chk("rstmid_async", {28'd0, cnt_m}, 32'd0);
    reset = 1'b0;
    q_m.push_back(8'h5A);
    q_l.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    chk("rstmid_q_m", q_m.size(), 32'd0);
    chk("rstmid_q_l", q_l.size(), 32'd0);
    mon_en = 1'b0;

    // reset while holding a word drops it
    word_ready = 1'b0;
    send_frame(8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rsthold_full", {31'd0, if_m.word_valid}, 32'd1);
    #2 reset = 1'b1;
    #1 chk("rsthold_valid", {31'd0, if_m.word_valid}, 32'd0);
    chk("rsthold_word", {24'd0, if_m.word_out}, 32'd0);
    reset = 1'b0;
    tick();

`ifdef BIT_DESER_PARITY_EN
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("par_err_pulse", {31'd0, perr_m}, 32'd1);
    chk("par_no_word", {31'd0, if_m.word_valid}, 32'd0);
    tick();
    chk("par_err_once", {31'd0, perr_m}, 32'd0);
    chk("par_no_ovf", {31'd0, ovf_m}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
